// File: rtl/reg_writeback_ctrl_pkg.sv
// rv_wb_pkg: load funct3 encodings, the in-flight load tag, and load data extraction
// shared by the write-back controller and its tag FIFO.
package rv_wb_pkg;

  localparam int unsigned WB_REG_SIZE  = 32;
  localparam int unsigned WB_ADDR_BITS = 5;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } ld_f3_e;

  // f3 is kept raw so unlisted encodings survive to the extractor and behave as LW.
  typedef struct packed {
    logic [WB_ADDR_BITS-1:0] rd;
    logic [2:0]              f3;
    logic [1:0]              off;
  } ld_tag_t;

  function automatic logic [WB_REG_SIZE-1:0] ld_extract(
    input logic [WB_REG_SIZE-1:0] word,
    input logic [2:0]             f3,
    input logic [1:0]             off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      LB:      ld_extract = {{(WB_REG_SIZE-8){b[7]}}, b};
      LBU:     ld_extract = {{(WB_REG_SIZE-8){1'b0}}, b};
      LH:      ld_extract = {{(WB_REG_SIZE-16){h[15]}}, h};
      LHU:     ld_extract = {{(WB_REG_SIZE-16){1'b0}}, h};
      default: ld_extract = word;
    endcase
  endfunction

  function automatic logic ld_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      LB, LBU: ld_misaligned = 1'b0;
      LH, LHU: ld_misaligned = off[0];
      default: ld_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/reg_writeback_ctrl_ld_tag_fifo.sv
// ld_tag_fifo: synchronous FIFO of outstanding load tags; every slot and its
// occupancy is exported so the controller can build the busy scoreboard.
module ld_tag_fifo
  import rv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  ld_tag_t                 push_tag,
  input  logic                    pop,
  output ld_tag_t                 head,
  output logic                    full,
  output logic                    empty,
  output ld_tag_t [DEPTH-1:0]     entries,
  output logic    [DEPTH-1:0]     valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  ld_tag_t [DEPTH-1:0] mem;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         count;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Slot i is live when its distance from the read pointer is below the fill count.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(i) - rd_ptr}) < count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: merges ALU results and in-order load responses into one registered
// reg-file write per cycle. Optional misaligned-load trap: RV_WB_MISALIGN_CHK_EN.
module reg_writeback_ctrl
  import rv_wb_pkg::*;
#(
  parameter int unsigned REG_SIZE  = 32,
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned LD_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [ADDR_BITS-1:0] alu_rd,
  input  logic [REG_SIZE-1:0]  alu_data,
  input  logic                 ld_issue_valid,
  input  logic [ADDR_BITS-1:0] ld_issue_rd,
  input  logic [2:0]           ld_issue_f3,
  input  logic [1:0]           ld_issue_off,
  output logic                 ld_issue_ready,
  input  logic                 mem_rvalid,
  input  logic [REG_SIZE-1:0]  mem_rdata,
  output logic                 mem_rready,
  input  logic [ADDR_BITS-1:0] rs1,
  input  logic [ADDR_BITS-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 WE,
  output logic [ADDR_BITS-1:0] A3,
  output logic [REG_SIZE-1:0]  WD
`ifdef RV_WB_MISALIGN_CHK_EN
  ,
  output logic                 ld_misalign
`endif
);

  logic                     alu_wr;
  logic                     push;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     ld_bad;
  ld_tag_t                  push_tag;
  ld_tag_t                  head;
  ld_tag_t [LD_DEPTH-1:0]   entries;
  logic    [LD_DEPTH-1:0]   valid;
  logic [(1<<ADDR_BITS)-1:0] pending;
  logic [REG_SIZE-1:0]      ld_data;

  assign alu_wr         = alu_valid && (alu_rd != '0);
  assign mem_rready     = mem_rvalid && !fifo_empty && !alu_wr;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the issue.
  assign ld_issue_ready = !fifo_full || mem_rready;
  assign push           = ld_issue_valid && ld_issue_ready;
  assign push_tag       = '{rd: ld_issue_rd, f3: ld_issue_f3, off: ld_issue_off};
  assign ld_data        = ld_extract(mem_rdata, head.f3, head.off);

`ifdef RV_WB_MISALIGN_CHK_EN
  assign ld_bad = ld_misaligned(head.f3, head.off);
`else
  assign ld_bad = 1'b0;
`endif

  ld_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_tag (push_tag),
    .pop      (mem_rready),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .entries  (entries),
    .valid    (valid)
  );

  // Scoreboard derived from live tags: a register stays busy while any queued load targets it.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      if (valid[i]) pending[entries[i].rd] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE <= 1'b0;
      A3 <= '0;
      WD <= '0;
    end else begin
      WE <= 1'b0;
      if (alu_wr) begin
        WE <= 1'b1;
        A3 <= alu_rd;
        WD <= alu_data;
      end else if (mem_rready && (head.rd != '0) && !ld_bad) begin
        WE <= 1'b1;
        A3 <= head.rd;
        WD <= ld_data;
      end
    end
  end

`ifdef RV_WB_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_misalign <= 1'b0;
    else        ld_misalign <= mem_rready && ld_bad;
  end
`endif

endmodule
